branch_trap_sequencer: RTL and testbench
========================================

# branch_trap_sequencer

Sequences SPARC Bicc/Ticc control flow behind the condition tester. It evaluates the branch/trap condition against the integer condition codes and redirects fetch for taken branches. It decides delay-slot annulment and runs the multi-cycle trap entry: PSR update, TBR load, saving PC/nPC into the new window, and the jump to the trap vector. It sits between decode and fetch and stalls fetch while a trap entry is in progress.

## Interface
- NWINDOWS, 8: number of register windows; CWP arithmetic is modulo this value.

- clk  in  1  rising-edge clock
- reset_n  in  1  reset, asynchronous and active-low
- instr_valid  in  1  decode presents an instruction this cycle
- instr  in  32  instruction word
- icc  in  4  {N,Z,V,C}
- trap_num  in  7  low 7 bits of the Ticc sum, from the datapath ALU
- pc, npc  in  32 each  PC and nPC of the presented instruction
- psr_cwp  in  3; psr_s, psr_et  in  1 each  current PSR fields
- tba  in  20  trap base address
- busy  out  1  stall fetch/decode
- redirect  out  1  one-cycle pulse: load redirect_pc into fetch
- redirect_pc  out  32  branch target or trap vector
- annul_next  out  1  one-cycle pulse: squash the delay-slot instruction
- rf_we  out  1; rf_waddr  out  5; rf_wdata  out  32  windowed register write, in new-window numbering
- psr_we  out  1; psr_new_cwp  out  3; psr_new_s, psr_new_ps, psr_new_et  out  1 each
- tbr_we  out  1; tbr_tt  out  8
- error_mode  out  1  sticky; trap taken with ET=0

## Operation
- Decode rules:
  - Bicc: instr[31:30]=00 and instr[24:22]=010.
  - Ticc: instr[31:30]=10 and instr[24:19]=111010.
  - cond = instr[28:25]; a = instr[29]; disp22 = instr[21:0].
  - Other instructions are ignored.
- Condition uses the SPARC V8 table (BA/BN/BNE/BE/BG/BLE/BGE/BL/BGU/BLEU/BCC/BCS/BPOS/BNEG/BVC/BVS) from icc.
- Bicc, accepted in IDLE:
  - target = pc + (sign_extend(disp22) << 2), modulo 2^32.
  - Taken → redirect=1, redirect_pc=target.
  - annul_next=1 when a=1 and either the branch is not taken or cond=BA.
  - Taken conditional branches with a=1 execute the delay slot.
  - Bicc takes no extra cycles and busy stays 0.
- Ticc, taken, psr_et=1: tt = {1'b1, trap_num}. FSM:
  - IDLE→T_PSR: psr_we=1; new_cwp=(cwp−1) mod NWINDOWS; new_s=1; new_ps=old s; new_et=0. tbr_we=1 with tbr_tt=tt.
  - T_PSR→T_L1: rf_we=1, rf_waddr=17, rf_wdata=pc.
  - T_L1→T_L2: rf_we=1, rf_waddr=18, rf_wdata=npc.
  - T_L2→T_JMP: redirect=1, redirect_pc={tba, tt, 4'b0000}; annul_next=1.
  - T_JMP→IDLE.
  - Operands (pc, npc, tt, old PSR) are latched at acceptance.
- Ticc, taken, psr_et=0: IDLE→ERROR. error_mode=1, busy=1, and the block stays in ERROR until reset.
- Ticc not taken: no effect.
- instr_valid while busy=1 is ignored; fetch is stalled.

## Timing
- Reset: state=IDLE. Every output is 0: busy, redirect, redirect_pc, annul_next, rf_we, rf_waddr, rf_wdata, psr_we, all psr_new_*, tbr_we, tbr_tt, error_mode.
- All outputs are registered.
- Bicc: redirect and annul_next assert in the cycle after acceptance, for exactly 1 cycle.
- Ticc:
  - busy is high from the cycle after acceptance through T_JMP (4 cycles).
  - Write strobes (psr_we, tbr_we, rf_we) are high for exactly 1 cycle each.
  - The redirect pulse occurs 4 cycles after acceptance.
- Back-to-back Bicc in consecutive cycles: each is accepted and produces its own pulse one cycle later.
- Reset asserted mid-trap: immediate return to IDLE with all outputs 0; none of the remaining writes are issued.
- CWP wrap: cwp=0 → new_cwp=NWINDOWS−1.

## Structure
- Shared package sparc_ctl_pkg holds:
  - opcode/op2/op3 constants
  - the 16 cond encodings
  - the state enum (IDLE, T_PSR, T_L1, T_L2, T_JMP, ERROR)
  - the local register indices 17 and 18
- Sub-module cond_eval: combinational (cond[3:0], icc[3:0]) → taken. It is shared with the condition tester's encoding.

## Test plan
- BE, Z=1, a=0, pc=0x00001000, disp22=0x000004 → redirect=1, redirect_pc=0x00001010, annul_next=0 one cycle later; busy=0.
- BNE, Z=1, a=1 → redirect=0, annul_next=1. BNE, Z=0, a=1 → redirect=1, annul_next=0.
- BA, a=1, pc=0x00001000, disp22=0x3FFFFF → redirect_pc=0x00000FFC, annul_next=1.
- TA, trap_num=5, cwp=0, s=0, et=1, tba=0x40000, pc=0x2000, npc=0x2004, NWINDOWS=8, checked per state:
  - T_PSR: cwp=7, s=1, ps=0, et=0; tt=0x85.
  - T_L1: r17=0x2000.
  - T_L2: r18=0x2004.
  - T_JMP: redirect_pc=0x40000850.
  - busy is high for 4 cycles.
- TA with et=0 → error_mode=1 and busy=1 permanently; no psr_we/rf_we; cleared only by reset_n=0.
- reset_n pulsed low during T_L1 → all outputs 0 immediately; no r18 write and no redirect afterwards; the next Bicc is handled normally.

Source files
------------

// File: rtl/sparc_ctl_pkg.sv
// Shared SPARC control encodings: instruction formats, branch conditions,
// trap-entry sequencing states and trap-window local register indices.
package sparc_ctl_pkg;

    localparam logic [1:0] OP_FMT2  = 2'b00;
    localparam logic [1:0] OP_FMT3  = 2'b10;
    localparam logic [2:0] OP2_BICC = 3'b010;
    localparam logic [5:0] OP3_TICC = 6'b111010;

    typedef enum logic [3:0] {
        COND_N   = 4'h0,
        COND_E   = 4'h1,
        COND_LE  = 4'h2,
        COND_L   = 4'h3,
        COND_LEU = 4'h4,
        COND_CS  = 4'h5,
        COND_NEG = 4'h6,
        COND_VS  = 4'h7,
        COND_A   = 4'h8,
        COND_NE  = 4'h9,
        COND_G   = 4'hA,
        COND_GE  = 4'hB,
        COND_GU  = 4'hC,
        COND_CC  = 4'hD,
        COND_POS = 4'hE,
        COND_VC  = 4'hF
    } cond_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        T_PSR = 3'd1,
        T_L1  = 3'd2,
        T_L2  = 3'd3,
        T_JMP = 3'd4,
        ERROR = 3'd5
    } state_e;

    localparam logic [4:0] REG_L1 = 5'd17;
    localparam logic [4:0] REG_L2 = 5'd18;

endpackage

// File: rtl/cond_eval.sv
// Integer condition evaluation for Bicc/Ticc; the upper half of the
// encoding space is the complement of the lower half.
module cond_eval
    import sparc_ctl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] icc,
    output logic       taken
);

    logic n, z, v, c;
    logic base;

    assign n = icc[3];
    assign z = icc[2];
    assign v = icc[1];
    assign c = icc[0];

    always_comb begin
        base = 1'b0;
        unique case (cond[2:0])
            3'd0: base = 1'b0;
            3'd1: base = z;
            3'd2: base = z | (n ^ v);
            3'd3: base = n ^ v;
            3'd4: base = c | z;
            3'd5: base = c;
            3'd6: base = n;
            3'd7: base = v;
            default: base = 1'b0;
        endcase
        taken = cond[3] ? ~base : base;
    end

endmodule

// File: rtl/branch_trap_sequencer.sv
// Bicc redirect/annul decisions and the multi-cycle Ticc trap entry
// (PSR/TBR update, PC/nPC save into the new window, vector jump).
module branch_trap_sequencer
    import sparc_ctl_pkg::*;
#(
    parameter int NWINDOWS = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    input  logic [3:0]  icc,
    input  logic [6:0]  trap_num,
    input  logic [31:0] pc,
    input  logic [31:0] npc,
    input  logic [2:0]  psr_cwp,
    input  logic        psr_s,
    input  logic        psr_et,
    input  logic [19:0] tba,
    output logic        busy,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        annul_next,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        psr_we,
    output logic [2:0]  psr_new_cwp,
    output logic        psr_new_s,
    output logic        psr_new_ps,
    output logic        psr_new_et,
    output logic        tbr_we,
    output logic [7:0]  tbr_tt,
    output logic        error_mode
);

    localparam logic [2:0] CWP_MAX = 3'(NWINDOWS - 1);

    logic        is_bicc;
    logic        is_ticc;
    logic        annul_bit;
    cond_e       cond;
    logic        taken;
    logic [31:0] target;
    logic [7:0]  tt_new;
    logic [2:0]  cwp_dec;

    assign is_bicc   = (instr[31:30] == OP_FMT2) && (instr[24:22] == OP2_BICC);
    assign is_ticc   = (instr[31:30] == OP_FMT3) && (instr[24:19] == OP3_TICC);
    assign annul_bit = instr[29];
    assign cond      = cond_e'(instr[28:25]);
    assign target    = pc + {{8{instr[21]}}, instr[21:0], 2'b00};
    assign tt_new    = {1'b1, trap_num};
    assign cwp_dec   = (psr_cwp == 3'd0) ? CWP_MAX : psr_cwp - 3'd1;

    cond_eval u_cond_eval (
        .cond  (instr[28:25]),
        .icc   (icc),
        .taken (taken)
    );

    state_e      state_q, state_d;
    logic        busy_q, busy_d;
    logic        redirect_q, redirect_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        annul_q, annul_d;
    logic        rf_we_q, rf_we_d;
    logic [4:0]  rf_waddr_q, rf_waddr_d;
    logic [31:0] rf_wdata_q, rf_wdata_d;
    logic        psr_we_q, psr_we_d;
    logic [2:0]  new_cwp_q, new_cwp_d;
    logic        new_s_q, new_s_d;
    logic        new_ps_q, new_ps_d;
    logic        new_et_q, new_et_d;
    logic        tbr_we_q, tbr_we_d;
    logic [7:0]  tbr_tt_q, tbr_tt_d;
    logic        err_q, err_d;
    logic [31:0] sav_pc_q, sav_pc_d;
    logic [31:0] sav_npc_q, sav_npc_d;
    logic [7:0]  sav_tt_q, sav_tt_d;
    logic [19:0] sav_tba_q, sav_tba_d;

    always_comb begin
        state_d       = state_q;
        busy_d        = 1'b0;
        redirect_d    = 1'b0;
        redirect_pc_d = '0;
        annul_d       = 1'b0;
        rf_we_d       = 1'b0;
        rf_waddr_d    = '0;
        rf_wdata_d    = '0;
        psr_we_d      = 1'b0;
        new_cwp_d     = '0;
        new_s_d       = 1'b0;
        new_ps_d      = 1'b0;
        new_et_d      = 1'b0;
        tbr_we_d      = 1'b0;
        tbr_tt_d      = '0;
        err_d         = 1'b0;
        sav_pc_d      = sav_pc_q;
        sav_npc_d     = sav_npc_q;
        sav_tt_d      = sav_tt_q;
        sav_tba_d     = sav_tba_q;
        unique case (state_q)
            IDLE: begin
                if (instr_valid && is_bicc) begin
                    redirect_d    = taken;
                    redirect_pc_d = taken ? target : '0;
                    // a=1 squashes the slot unless a conditional branch is taken
                    annul_d       = annul_bit & (~taken | (cond == COND_A));
                end else if (instr_valid && is_ticc && taken) begin
                    busy_d = 1'b1;
                    if (psr_et) begin
                        state_d   = T_PSR;
                        psr_we_d  = 1'b1;
                        new_cwp_d = cwp_dec;
                        new_s_d   = 1'b1;
                        new_ps_d  = psr_s;
                        tbr_we_d  = 1'b1;
                        tbr_tt_d  = tt_new;
                        sav_pc_d  = pc;
                        sav_npc_d = npc;
                        sav_tt_d  = tt_new;
                        sav_tba_d = tba;
                    end else begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end
                end
            end
            T_PSR: begin
                state_d    = T_L1;
                busy_d     = 1'b1;
                rf_we_d    = 1'b1;
                rf_waddr_d = REG_L1;
                rf_wdata_d = sav_pc_q;
            end
            T_L1: begin
                state_d    = T_L2;
                busy_d     = 1'b1;
                rf_we_d    = 1'b1;
                rf_waddr_d = REG_L2;
                rf_wdata_d = sav_npc_q;
            end
            T_L2: begin
                state_d       = T_JMP;
                busy_d        = 1'b1;
                redirect_d    = 1'b1;
                redirect_pc_d = {sav_tba_q, sav_tt_q, 4'b0000};
                annul_d       = 1'b1;
            end
            T_JMP: state_d = IDLE;
            ERROR: begin
                busy_d = 1'b1;
                err_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            busy_q        <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            annul_q       <= 1'b0;
            rf_we_q       <= 1'b0;
            rf_waddr_q    <= '0;
            rf_wdata_q    <= '0;
            psr_we_q      <= 1'b0;
            new_cwp_q     <= '0;
            new_s_q       <= 1'b0;
            new_ps_q      <= 1'b0;
            new_et_q      <= 1'b0;
            tbr_we_q      <= 1'b0;
            tbr_tt_q      <= '0;
            err_q         <= 1'b0;
            sav_pc_q      <= '0;
            sav_npc_q     <= '0;
            sav_tt_q      <= '0;
            sav_tba_q     <= '0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            annul_q       <= annul_d;
            rf_we_q       <= rf_we_d;
            rf_waddr_q    <= rf_waddr_d;
            rf_wdata_q    <= rf_wdata_d;
            psr_we_q      <= psr_we_d;
            new_cwp_q     <= new_cwp_d;
            new_s_q       <= new_s_d;
            new_ps_q      <= new_ps_d;
            new_et_q      <= new_et_d;
            tbr_we_q      <= tbr_we_d;
            tbr_tt_q      <= tbr_tt_d;
            err_q         <= err_d;
            sav_pc_q      <= sav_pc_d;
            sav_npc_q     <= sav_npc_d;
            sav_tt_q      <= sav_tt_d;
            sav_tba_q     <= sav_tba_d;
        end
    end

    assign busy        = busy_q;
    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;
    assign annul_next  = annul_q;
    assign rf_we       = rf_we_q;
    assign rf_waddr    = rf_waddr_q;
    assign rf_wdata    = rf_wdata_q;
    assign psr_we      = psr_we_q;
    assign psr_new_cwp = new_cwp_q;
    assign psr_new_s   = new_s_q;
    assign psr_new_ps  = new_ps_q;
    assign psr_new_et  = new_et_q;
    assign tbr_we      = tbr_we_q;
    assign tbr_tt      = tbr_tt_q;
    assign error_mode  = err_q;

endmodule

// File: tb/tb_branch_trap_sequencer.sv
// Directed and randomized checks of branch_trap_sequencer against a
// cycle-list reference model derived from SPARC Bicc/Ticc semantics.
module tb_branch_trap_sequencer;

    localparam int NW = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        instr_valid;
    logic [31:0] instr;
    logic [3:0]  icc;
    logic [6:0]  trap_num;
    logic [31:0] pc, npc;
    logic [2:0]  psr_cwp;
    logic        psr_s, psr_et;
    logic [19:0] tba;
    logic        busy, redirect, annul_next, rf_we, psr_we;
    logic [31:0] redirect_pc, rf_wdata;
    logic [4:0]  rf_waddr;
    logic [2:0]  psr_new_cwp;
    logic        psr_new_s, psr_new_ps, psr_new_et;
    logic        tbr_we, error_mode;
    logic [7:0]  tbr_tt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        busy, redir;
        logic [31:0] rpc;
        logic        annul, rf_we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        psr_we;
        logic [2:0]  cwp;
        logic        s, ps, et, tbr_we;
        logic [7:0]  tt;
        logic        err;
    } exp_t;

    always #5 clk = ~clk;

    branch_trap_sequencer #(.NWINDOWS(NW)) dut (
        .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid),
        .instr(instr), .icc(icc), .trap_num(trap_num), .pc(pc), .npc(npc),
        .psr_cwp(psr_cwp), .psr_s(psr_s), .psr_et(psr_et), .tba(tba),
        .busy(busy), .redirect(redirect), .redirect_pc(redirect_pc),
        .annul_next(annul_next), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .psr_we(psr_we), .psr_new_cwp(psr_new_cwp),
        .psr_new_s(psr_new_s), .psr_new_ps(psr_new_ps),
        .psr_new_et(psr_new_et), .tbr_we(tbr_we), .tbr_tt(tbr_tt),
        .error_mode(error_mode)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t quiet();
        exp_t e;
        e = '{default: '0};
        return e;
    endfunction

    task automatic check_outs(input string tag, input exp_t e);
        chk({tag, ".busy"},   32'(busy),        32'(e.busy));
        chk({tag, ".redir"},  32'(redirect),    32'(e.redir));
        chk({tag, ".rpc"},    redirect_pc,      e.rpc);
        chk({tag, ".annul"},  32'(annul_next),  32'(e.annul));
        chk({tag, ".rf_we"},  32'(rf_we),       32'(e.rf_we));
        chk({tag, ".waddr"},  32'(rf_waddr),    32'(e.waddr));
        chk({tag, ".wdata"},  rf_wdata,         e.wdata);
        chk({tag, ".psr_we"}, 32'(psr_we),      32'(e.psr_we));
        chk({tag, ".cwp"},    32'(psr_new_cwp), 32'(e.cwp));
        chk({tag, ".s"},      32'(psr_new_s),   32'(e.s));
        chk({tag, ".ps"},     32'(psr_new_ps),  32'(e.ps));
        chk({tag, ".et"},     32'(psr_new_et),  32'(e.et));
        chk({tag, ".tbr_we"}, 32'(tbr_we),      32'(e.tbr_we));
        chk({tag, ".tt"},     32'(tbr_tt),      32'(e.tt));
        chk({tag, ".err"},    32'(error_mode),  32'(e.err));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // SPARC V8 integer condition table, icc = {N,Z,V,C}
    function automatic bit cond_true(input bit [3:0] c, input bit [3:0] f);
        bit n, z, v, cy;
        n = f[3]; z = f[2]; v = f[1]; cy = f[0];
        case (c)
            4'd8:  return 1'b1;
            4'd0:  return 1'b0;
            4'd9:  return !z;
            4'd1:  return z;
            4'd10: return !z && (n == v);
            4'd2:  return z || (n != v);
            4'd11: return n == v;
            4'd3:  return n != v;
            4'd12: return !cy && !z;
            4'd4:  return cy || z;
            4'd13: return !cy;
            4'd5:  return cy;
            4'd14: return !n;
            4'd6:  return n;
            4'd15: return !v;
            default: return v;
        endcase
    endfunction

    function automatic logic [31:0] br_target(input logic [31:0] p,
                                              input logic [21:0] d);
        longint off;
        off = longint'(d);
        if (off >= 64'sd2097152) off = off - 64'sd4194304;
        return 32'(longint'(p) + off * 4);
    endfunction

    function automatic logic [31:0] mk_bicc(input bit a, input bit [3:0] c,
                                            input bit [21:0] d);
        return {2'b00, a, c, 3'b010, d};
    endfunction

    function automatic logic [31:0] mk_ticc(input bit [3:0] c,
                                            input bit [18:0] lo);
        return {2'b10, 1'b0, c, 6'b111010, lo};
    endfunction

    function automatic exp_t bicc_exp(input logic [31:0] w);
        exp_t e;
        bit t;
        e = quiet();
        t = cond_true(w[28:25], icc);
        e.redir = t;
        e.rpc   = t ? br_target(pc, w[21:0]) : 32'h0;
        e.annul = w[29] && (!t || w[28:25] == 4'd8);
        return e;
    endfunction

    task automatic run_txn(input string tag, input logic [31:0] w);
        bit   is_b, is_t, t;
        exp_t e;
        exp_t q[$];
        int   ttv;
        is_b = (w[31:30] == 2'b00) && (w[24:22] == 3'b010);
        is_t = (w[31:30] == 2'b10) && (w[24:19] == 6'b111010);
        t    = cond_true(w[28:25], icc);
        instr       = w;
        instr_valid = 1'b1;
        tick();
        if (is_b) begin
            check_outs({tag, ".b"}, bicc_exp(w));
        end else if (is_t && t && psr_et) begin
            ttv = 128 + int'(trap_num);
            e = quiet(); e.busy = 1; e.psr_we = 1;
            e.cwp = 3'((int'(psr_cwp) + NW - 1) % NW);
            e.s = 1; e.ps = psr_s; e.et = 0; e.tbr_we = 1; e.tt = 8'(ttv);
            q.push_back(e);
            e = quiet(); e.busy = 1; e.rf_we = 1; e.waddr = 17; e.wdata = pc;
            q.push_back(e);
            e = quiet(); e.busy = 1; e.rf_we = 1; e.waddr = 18; e.wdata = npc;
            q.push_back(e);
            e = quiet(); e.busy = 1; e.redir = 1; e.annul = 1;
            e.rpc = 32'(longint'(tba) * 4096 + ttv * 16);
            q.push_back(e);
            check_outs({tag, ".t0"}, q[0]);
            instr = mk_bicc(1'b0, 4'd8, 22'($urandom));
            for (int k = 1; k < 4; k++) begin
                tick();
                check_outs($sformatf("%s.t%0d", tag, k), q[k]);
            end
        end else if (is_t && t) begin
            e = quiet(); e.busy = 1; e.err = 1;
            check_outs({tag, ".e0"}, e);
            instr = mk_bicc(1'b0, 4'd8, 22'($urandom));
            for (int k = 1; k < 4; k++) begin
                tick();
                check_outs($sformatf("%s.e%0d", tag, k), e);
            end
            reset_n = 1'b0;
            #1;
            check_outs({tag, ".erst"}, quiet());
            reset_n = 1'b1;
        end else begin
            check_outs({tag, ".nop"}, quiet());
        end
        instr_valid = 1'b0;
        tick();
        check_outs({tag, ".idle"}, quiet());
    endtask

    initial begin
        logic [31:0] w1, w2;
        int kind;
        reset_n = 1'b0; instr_valid = 1'b0; instr = '0; icc = '0;
        trap_num = '0; pc = '0; npc = '0; psr_cwp = '0; psr_s = 1'b0;
        psr_et = 1'b0; tba = '0;
        repeat (2) tick();
        check_outs("reset", quiet());
        reset_n = 1'b1;
        tick();

        icc = 4'b0100; pc = 32'h1000;
        run_txn("be_z1", mk_bicc(1'b0, 4'd1, 22'h000004));
        run_txn("bne_z1_a", mk_bicc(1'b1, 4'd9, 22'h000010));
        icc = 4'b0000;
        run_txn("bne_z0_a", mk_bicc(1'b1, 4'd9, 22'h000010));
        run_txn("ba_neg_a", mk_bicc(1'b1, 4'd8, 22'h3FFFFF));
        run_txn("bn_a", mk_bicc(1'b1, 4'd0, 22'h000123));

        icc = 4'b1000;
        w1 = mk_bicc(1'b0, 4'd3, 22'h000040);
        w2 = mk_bicc(1'b1, 4'd11, 22'h200000);
        instr = w1; instr_valid = 1'b1;
        tick();
        check_outs("b2b.first", bicc_exp(w1));
        instr = w2;
        tick();
        check_outs("b2b.second", bicc_exp(w2));
        instr_valid = 1'b0;
        tick();
        check_outs("b2b.idle", quiet());

        trap_num = 7'd5; psr_cwp = 3'd0; psr_s = 1'b0; psr_et = 1'b1;
        tba = 20'h40000; pc = 32'h2000; npc = 32'h2004;
        run_txn("ta", mk_ticc(4'd8, 19'h02005));
        psr_et = 1'b0;
        run_txn("ta_et0", mk_ticc(4'd8, 19'h02005));

        psr_et = 1'b1;
        instr = mk_ticc(4'd8, 19'h0); instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        chk("mid.l1_we", 32'(rf_we), 32'd1);
        chk("mid.l1_addr", 32'(rf_waddr), 32'd17);
        #2 reset_n = 1'b0;
        #1 check_outs("mid.rst", quiet());
        #3 reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_outs($sformatf("mid.after%0d", k), quiet());
        end
        icc = 4'b0001; pc = 32'h3000;
        run_txn("mid.bcs", mk_bicc(1'b0, 4'd5, 22'h000008));

        for (int i = 0; i < 300; i++) begin
            icc = 4'($urandom); pc = {$urandom} & 32'hFFFFFFFC;
            npc = pc + 32'd4; trap_num = 7'($urandom);
            psr_cwp = 3'($urandom); psr_s = 1'($urandom);
            psr_et = ($urandom_range(0, 5) != 0); tba = 20'($urandom);
            kind = $urandom_range(0, 5);
            case (kind)
                0, 1, 2: w1 = mk_bicc(1'($urandom), 4'($urandom), 22'($urandom));
                3, 4:    w1 = mk_ticc(4'($urandom), 19'($urandom));
                default: w1 = {2'b01, 30'($urandom)};
            endcase
            run_txn($sformatf("rnd%0d", i), w1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
